// File: rtl/rand_range_gen.sv
`default_nettype none
// ============================================================================
// Module  : rand_range_gen
// Brief   : Free-running Galois LFSR sample mapped into [min, max] using a
//           bit-serial restoring modulo, delivered over valid/ready.
//           Optional macro RAND_NO_REPEAT_EN adds a FIX cycle that prevents
//           the same result from being delivered twice in a row.
// Revision: 1.0
// ============================================================================
module rand_range_gen #(
    parameter int             W    = 16,
    parameter logic [W-1:0]   TAPS = 16'hB400,
    parameter logic [W-1:0]   SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] min,
    input  logic [W-1:0] max,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_num,
    output logic         err
);

    localparam int             IDXW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0]   C_SEED    = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;
    localparam logic [IDXW-1:0] C_IDX_MSB = IDXW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_lfsr;
    logic [W-1:0]    r_min;
    logic [W-1:0]    r_sample;
    logic [W:0]      r_total;
    logic [W-1:0]    r_rem;
    logic [IDXW-1:0] r_idx;
    logic            r_bad;
    logic            r_busy;
    logic            r_valid;
    logic            r_err;
    logic [W-1:0]    r_out_num;

    logic [W-1:0]    w_lfsr_next;
    logic [W:0]      w_shift;
    logic [W-1:0]    w_sub;
    logic [W-1:0]    w_sum;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    // Remainder never exceeds total-1, so the low W bits of the difference are exact.
    assign w_shift     = {r_rem, r_sample[r_idx]};
    assign w_sub       = w_shift[W-1:0] - r_total[W-1:0];
    assign w_sum       = r_min + r_rem;

`ifdef RAND_NO_REPEAT_EN
    logic [W-1:0] r_last;
    logic         r_last_vld;
    logic [W:0]   w_rem_inc;
    logic         w_hit;

    assign w_rem_inc = {1'b0, r_rem} + (W+1)'(1);
    assign w_hit     = r_last_vld && (r_total > (W+1)'(1)) && (w_sum == r_last);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lfsr    <= C_SEED;
            r_min     <= '0;
            r_sample  <= '0;
            r_total   <= '0;
            r_rem     <= '0;
            r_idx     <= '0;
            r_bad     <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_out_num <= '0;
`ifdef RAND_NO_REPEAT_EN
            r_last     <= '0;
            r_last_vld <= 1'b0;
`endif
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_min    <= min;
                        r_sample <= r_lfsr;
                        r_total  <= {1'b0, max} - {1'b0, min} + (W+1)'(1);
                        r_rem    <= '0;
                        r_idx    <= C_IDX_MSB;
                        r_busy   <= 1'b1;
                        r_bad    <= (min > max);
                        // Error requests skip the modulo; rem=0 makes the result equal min.
                        r_state  <= (min > max) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= (w_shift >= r_total) ? w_sub : w_shift[W-1:0];
                    r_idx <= r_idx - IDXW'(1);
                    if (r_idx == '0) begin
`ifdef RAND_NO_REPEAT_EN
                        r_state <= S_FIX;
`else
                        r_state <= S_DONE;
`endif
                    end
                end
`ifdef RAND_NO_REPEAT_EN
                S_FIX: begin
                    if (w_hit) begin
                        r_rem <= (w_rem_inc == r_total) ? '0 : w_rem_inc[W-1:0];
                    end
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (!r_valid) begin
                        r_valid   <= 1'b1;
                        r_out_num <= w_sum;
                        r_err     <= r_bad;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef RAND_NO_REPEAT_EN
                        if (!r_bad) begin
                            r_last     <= r_out_num;
                            r_last_vld <= 1'b1;
                        end
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_num   = r_out_num;
    assign err       = r_err;

endmodule
`default_nettype wire
